usb_read_arbiter: RTL and testbench



---
 rtl/usb_read_arbiter.sv | 137 +++++++++++++
 tb/tb_usb_read_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_read_arbiter.sv
// Round-robin read-lock arbiter that hands the USB read port to one requester at a time.
// Optional grant watchdog is compiled in with `define USB_ARB_TIMEOUT_EN.
module usb_read_arbiter #(
    parameter int pREQUESTERS = 4,
    parameter int pDATA_WIDTH = 8,
    parameter int pTIMEOUT    = 1024
) (
    input  logic                                   clk_usb,
    input  logic                                   reset,
    input  logic [pREQUESTERS-1:0]                 req,
    input  logic                                   rd_strobe,
    input  logic [pREQUESTERS*pDATA_WIDTH-1:0]     data_in,
    input  logic                                   clear_timeout,
    output logic [pREQUESTERS-1:0]                 grant,
    output logic [$clog2(pREQUESTERS > 1 ? pREQUESTERS : 2)-1:0] owner,
    output logic                                   busy,
    output logic [pREQUESTERS-1:0]                 rd_strobe_out,
    output logic [pDATA_WIDTH-1:0]                 data_out,
    output logic                                   timeout_flag
);

    localparam int N  = pREQUESTERS;
    localparam int OW = $clog2(pREQUESTERS > 1 ? pREQUESTERS : 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    grant_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   last_owner_q;

    logic [N-1:0]    elig;
    logic            found;
    logic [OW-1:0]   pick;
    logic [N-1:0]    pick_oh;

`ifdef USB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(pTIMEOUT + 1);

    logic [TW-1:0]   tmr_q;
    logic [N-1:0]    revoke_q;
    logic            timeout_flag_q;

    // A revoked requester stays out until it has dropped req for an edge.
    assign elig         = req & ~revoke_q;
    assign timeout_flag = timeout_flag_q;
`else
    logic            unused_cfg;

    assign elig         = req;
    assign timeout_flag = 1'b0;
    assign unused_cfg   = clear_timeout ^ (pTIMEOUT == 0);
`endif

    // First eligible requester after the last owner, wrapping.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && elig[(int'(last_owner_q) + k) % N]) begin
                found                                 = 1'b1;
                pick                                  = OW'((int'(last_owner_q) + k) % N);
                pick_oh[(int'(last_owner_q) + k) % N] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            owner_q        <= '0;
            last_owner_q   <= OW'(N - 1);
`ifdef USB_ARB_TIMEOUT_EN
            tmr_q          <= '0;
            revoke_q       <= '0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
`ifdef USB_ARB_TIMEOUT_EN
            revoke_q <= revoke_q & req;
            if (clear_timeout) begin
                timeout_flag_q <= 1'b0;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        grant_q <= pick_oh;
                        owner_q <= pick;
                        state_q <= S_GRANT;
`ifdef USB_ARB_TIMEOUT_EN
                        tmr_q   <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (!req[owner_q]) begin
                        grant_q      <= '0;
                        last_owner_q <= owner_q;
                        state_q      <= S_TURN;
`ifdef USB_ARB_TIMEOUT_EN
                    end else if (tmr_q == TW'(pTIMEOUT - 1)) begin
                        // Set wins over a coincident clear_timeout.
                        grant_q        <= '0;
                        last_owner_q   <= owner_q;
                        state_q        <= S_TURN;
                        revoke_q       <= (revoke_q & req) | grant_q;
                        timeout_flag_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
`endif
                    end
                end
                S_TURN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign owner         = owner_q;
    assign busy          = |grant_q;
    assign rd_strobe_out = grant_q & {N{rd_strobe}};
    assign data_out      = busy ? data_in[int'(owner_q)*pDATA_WIDTH +: pDATA_WIDTH] : '0;

endmodule

// File: tb/tb_usb_read_arbiter.sv
// Directed bench for usb_read_arbiter: vector table plus round-robin, strobe, reset and watchdog sequences.
// The watchdog sequence runs only when USB_ARB_TIMEOUT_EN is defined.
module tb_usb_read_arbiter;

    logic        clk_usb = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        rd_strobe;
    logic [31:0] data_in;
    logic        clear_timeout;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  rd_strobe_out;
    logic [7:0]  data_out;
    logic        timeout_flag;

    int total = 0;
    int bad   = 0;

    usb_read_arbiter #(
        .pREQUESTERS(4),
        .pDATA_WIDTH(8),
        .pTIMEOUT   (16)
    ) dut (
        .clk_usb      (clk_usb),
        .reset        (reset),
        .req          (req),
        .rd_strobe    (rd_strobe),
        .data_in      (data_in),
        .clear_timeout(clear_timeout),
        .grant        (grant),
        .owner        (owner),
        .busy         (busy),
        .rd_strobe_out(rd_strobe_out),
        .data_out     (data_out),
        .timeout_flag (timeout_flag)
    );

    always #5 clk_usb = ~clk_usb;

    typedef struct {
        logic [3:0] req;
        logic       stb;
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic [3:0] rso;
        logic [7:0] d;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        req           = 4'b0000;
        rd_strobe     = 1'b0;
        clear_timeout = 1'b0;
        repeat (2) @(posedge clk_usb);
        @(negedge clk_usb);
        reset = 1'b0;
    endtask

    initial begin
        data_in = 32'h44A5_2211;

        // Hand-computed cycle table starting from reset (last owner = 3).
        vt[0]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 8'h11};
        vt[1]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001, 8'h11};
        vt[2]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 8'h11};
        vt[3]  = '{4'b1110, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[4]  = '{4'b1110, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[5]  = '{4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 8'h22};
        vt[6]  = '{4'b1100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[7]  = '{4'b1101, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[8]  = '{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 8'hA5};
        vt[9]  = '{4'b1101, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100, 8'hA5};
        vt[10] = '{4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[11] = '{4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[12] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b0000, 8'h44};
        vt[13] = '{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[14] = '{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00};
        vt[15] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 8'h11};

        reset         = 1'b1;
        req           = 4'b0000;
        rd_strobe     = 1'b0;
        clear_timeout = 1'b0;
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_owner", owner, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_tflag", timeout_flag, 1'b0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            @(negedge clk_usb);
            req       = vt[i].req;
            rd_strobe = vt[i].stb;
            tick();
            check($sformatf("vec%0d_grant", i), grant, vt[i].g);
            check($sformatf("vec%0d_busy", i), busy, vt[i].b);
            if (vt[i].b) check($sformatf("vec%0d_owner", i), owner, vt[i].o);
            check($sformatf("vec%0d_rso", i), rd_strobe_out, vt[i].rso);
            check($sformatf("vec%0d_data", i), data_out, vt[i].d);
`ifndef USB_ARB_TIMEOUT_EN
            check($sformatf("vec%0d_tflag", i), timeout_flag, 1'b0);
`endif
        end

        // Requester 2 owns the bus while rd_strobe pulses four times.
        begin
            logic [7:0] pat;
            int         pulses;
            int         waited;
            pat    = 8'b0101_1010;
            pulses = 0;
            waited = 0;
            @(negedge clk_usb);
            req       = 4'b0000;
            rd_strobe = 1'b0;
            tick();
            req = 4'b0100;
            tick();
            while (grant != 4'b0100 && waited < 10) begin
                waited++;
                tick();
            end
            check("stb_owner", owner, 2'd2);
            for (int c = 0; c < 8; c++) begin
                @(negedge clk_usb);
                rd_strobe = pat[c];
                tick();
                check($sformatf("stb%0d_rso", c), rd_strobe_out, pat[c] ? 4'b0100 : 4'b0000);
                check($sformatf("stb%0d_data", c), data_out, 8'hA5);
                if (rd_strobe_out == 4'b0100) pulses++;
            end
            check("stb_pulses", pulses, 4);
            rd_strobe = 1'b0;
        end

        // Round robin with all four requesting, each owner holding 3 cycles.
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int gap;
            gap = 0;
            tick();
            while (grant == 4'b0000 && gap < 10) begin
                gap++;
                tick();
            end
            check($sformatf("rr%0d_grant", n), grant, 4'b0001 << (n % 4));
            check($sformatf("rr%0d_owner", n), owner, n % 4);
            if (n > 0) check($sformatf("rr%0d_idle_gap", n), gap, 1);
            repeat (2) tick();
            check($sformatf("rr%0d_held", n), grant, 4'b0001 << (n % 4));
            req[n % 4] = 1'b0;
            tick();
            check($sformatf("rr%0d_release", n), busy, 1'b0);
            req = 4'b1111;
        end

        // Reset mid-cycle while requester 1 owns the bus.
        begin
            int waited;
            waited = 0;
            req = 4'b0010;
            tick();
            while (grant != 4'b0010 && waited < 10) begin
                waited++;
                tick();
            end
            check("mid_pre_grant", grant, 4'b0010);
            #2;
            reset = 1'b1;
            #1;
            check("mid_rst_grant", grant, 4'b0000);
            check("mid_rst_busy", busy, 1'b0);
            @(negedge clk_usb);
            req = 4'b1001;
            @(negedge clk_usb);
            reset = 1'b0;
            tick();
            check("post_rst_grant", grant, 4'b0001);
            check("post_rst_owner", owner, 2'd0);
            req = 4'b0000;
            tick();
            req = 4'b0010;
            repeat (2) tick();
            check("post_rst_r1_grant", grant, 4'b0010);
        end

`ifdef USB_ARB_TIMEOUT_EN
        // Watchdog: requester 0 holds forever; clear coincides with the revoke edge.
        begin
            int cnt;
            cnt = 0;
            do_reset();
            req = 4'b0011;
            tick();
            while (grant == 4'b0001 && cnt < 40) begin
                cnt++;
                if (cnt == 16) clear_timeout = 1'b1;
                tick();
                clear_timeout = 1'b0;
            end
            check("to_cycles", cnt, 16);
            check("to_revoked", grant, 4'b0000);
            check("to_flag_set_wins", timeout_flag, 1'b1);
            tick();
            check("to_turn", grant, 4'b0000);
            tick();
            check("to_next_grant", grant, 4'b0010);
            req = 4'b0001;
            repeat (3) tick();
            check("to_masked_a", grant, 4'b0000);
            tick();
            check("to_masked_b", grant, 4'b0000);
            req = 4'b0000;
            tick();
            req = 4'b0001;
            tick();
            check("to_regrant", grant, 4'b0001);
            check("to_flag_kept", timeout_flag, 1'b1);
            clear_timeout = 1'b1;
            tick();
            clear_timeout = 1'b0;
            check("to_flag_cleared", timeout_flag, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
